// File: rtl/rgb_yuv_pkg.sv
// rtl/rgb_yuv_pkg.sv - shared types and BT.601 studio-range coefficients for the RGB->YUV encoder
package rgb_yuv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MR,
        S_MG,
        S_MB,
        S_OUT
    } rgb_yuv_state_e;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 18;
    localparam int PROD_W = 27;

    // Q16 coefficients; each chroma row sums to zero so grey maps to 128
    localparam logic signed [COEF_W-1:0] C_Y_R =  18'sd16843;
    localparam logic signed [COEF_W-1:0] C_Y_G =  18'sd33030;
    localparam logic signed [COEF_W-1:0] C_Y_B =  18'sd6423;
    localparam logic signed [COEF_W-1:0] C_U_R = -18'sd9699;
    localparam logic signed [COEF_W-1:0] C_U_G = -18'sd19071;
    localparam logic signed [COEF_W-1:0] C_U_B =  18'sd28770;
    localparam logic signed [COEF_W-1:0] C_V_R =  18'sd28770;
    localparam logic signed [COEF_W-1:0] C_V_G = -18'sd24117;
    localparam logic signed [COEF_W-1:0] C_V_B = -18'sd4653;

    localparam int Y_OFS  = 16;
    localparam int UV_OFS = 128;

endpackage

// File: rtl/rgb_to_yuv_converter_if.sv
// rtl/rgb_to_yuv_converter_if.sv - pixel-in / YUV-out handshake bundle for the RGB->YUV encoder
interface rgb_to_yuv_converter_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] R_in;
    logic [7:0] G_in;
    logic [7:0] B_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Y_out;
    logic [7:0] U_out;
    logic [7:0] V_out;
    logic       uv_valid;

    // Pixel source and YUV writer side
    modport master (
        output in_valid, R_in, G_in, B_in, out_ready,
        input  in_ready, out_valid, Y_out, U_out, V_out, uv_valid
    );

    // Converter side
    modport slave (
        input  in_valid, R_in, G_in, B_in, out_ready,
        output in_ready, out_valid, Y_out, U_out, V_out, uv_valid
    );

endinterface

// File: rtl/yuv_round_clip.sv
// rtl/yuv_round_clip.sv - round a Q-format accumulator to integer, add channel offset, clip to 0..255
module yuv_round_clip #(
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 16,
    parameter int OFFSET    = 16
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [7:0]       ch_o
);

    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1 << (FRAC_BITS - 1));
    localparam logic signed [ACC_W-1:0] OFS  = ACC_W'(OFFSET);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(255);

    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] ch;

    // Round half up, floor-shift, add offset and saturate to an unsigned byte
    always_comb begin
        rounded = (acc_i + RND) >>> FRAC_BITS;
        ch      = rounded + OFS;
        if (ch < 0) begin
            ch_o = 8'd0;
        end else if (ch > MAXV) begin
            ch_o = 8'd255;
        end else begin
            ch_o = ch[7:0];
        end
    end

endmodule

// File: rtl/rgb_to_yuv_converter.sv
// rtl/rgb_to_yuv_converter.sv - RGB888 to BT.601 YUV encoder, three multipliers shared over R/G/B; optional CHROMA_422_EN
module rgb_to_yuv_converter
    import rgb_yuv_pkg::*;
#(
    parameter int FRAC_BITS = 16,
    parameter int ACC_W     = 32
) (
    input  logic                 CLOCK_50_I,
    input  logic                 resetn,
    rgb_to_yuv_converter_if.slave bus
);

    rgb_yuv_state_e state_q, state_d;

    logic [PIX_W-1:0] r_q, r_d;
    logic [PIX_W-1:0] g_q, g_d;
    logic [PIX_W-1:0] b_q, b_d;

    logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
    logic signed [ACC_W-1:0] acc_u_q, acc_u_d;
    logic signed [ACC_W-1:0] acc_v_q, acc_v_d;

    logic       out_valid_q, out_valid_d;
    logic       uv_valid_q,  uv_valid_d;
    logic [7:0] y_out_q, y_out_d;
    logic [7:0] u_out_q, u_out_d;
    logic [7:0] v_out_q, v_out_d;

`ifdef CHROMA_422_EN
    logic       pair_q, pair_d;
    logic [7:0] u_hold_q, u_hold_d;
    logic [7:0] v_hold_q, v_hold_d;
    logic [8:0] u_sum;
    logic [8:0] v_sum;
`endif

    logic [PIX_W-1:0]         pix_sel;
    logic signed [PIX_W:0]    op;
    logic signed [COEF_W-1:0] coef_y, coef_u, coef_v;
    logic signed [PROD_W-1:0] prod_y, prod_u, prod_v;
    logic signed [ACC_W-1:0]  acc_nxt_y, acc_nxt_u, acc_nxt_v;
    logic [7:0]               y_clip, u_clip, v_clip;

    // Pick the colour operand and its three coefficients for the current multiply step
    always_comb begin
        case (state_q)
            S_MG: begin
                pix_sel = g_q;
                coef_y  = C_Y_G;
                coef_u  = C_U_G;
                coef_v  = C_V_G;
            end
            S_MB: begin
                pix_sel = b_q;
                coef_y  = C_Y_B;
                coef_u  = C_U_B;
                coef_v  = C_V_B;
            end
            default: begin
                pix_sel = r_q;
                coef_y  = C_Y_R;
                coef_u  = C_U_R;
                coef_v  = C_V_R;
            end
        endcase
    end

    assign op     = $signed({1'b0, pix_sel});
    assign prod_y = op * coef_y;
    assign prod_u = op * coef_u;
    assign prod_v = op * coef_v;

    // The red step starts a fresh sum; green and blue add onto the running totals
    always_comb begin
        if (state_q == S_MR) begin
            acc_nxt_y = ACC_W'(prod_y);
            acc_nxt_u = ACC_W'(prod_u);
            acc_nxt_v = ACC_W'(prod_v);
        end else begin
            acc_nxt_y = acc_y_q + ACC_W'(prod_y);
            acc_nxt_u = acc_u_q + ACC_W'(prod_u);
            acc_nxt_v = acc_v_q + ACC_W'(prod_v);
        end
    end

    // Rounding sees the completed sum during the blue step so results land on entry to S_OUT
    yuv_round_clip #(.ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS), .OFFSET(Y_OFS)) u_clip_y (
        .acc_i (acc_nxt_y),
        .ch_o  (y_clip)
    );

    yuv_round_clip #(.ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS), .OFFSET(UV_OFS)) u_clip_u (
        .acc_i (acc_nxt_u),
        .ch_o  (u_clip)
    );

    yuv_round_clip #(.ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS), .OFFSET(UV_OFS)) u_clip_v (
        .acc_i (acc_nxt_v),
        .ch_o  (v_clip)
    );

    // Next-state and datapath control for the idle/multiply/output sequence
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        acc_y_d     = acc_y_q;
        acc_u_d     = acc_u_q;
        acc_v_d     = acc_v_q;
        out_valid_d = out_valid_q;
        uv_valid_d  = uv_valid_q;
        y_out_d     = y_out_q;
        u_out_d     = u_out_q;
        v_out_d     = v_out_q;
`ifdef CHROMA_422_EN
        pair_d      = pair_q;
        u_hold_d    = u_hold_q;
        v_hold_d    = v_hold_q;
        u_sum       = {1'b0, u_hold_q} + {1'b0, u_clip} + 9'd1;
        v_sum       = {1'b0, v_hold_q} + {1'b0, v_clip} + 9'd1;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    r_d     = bus.R_in;
                    g_d     = bus.G_in;
                    b_d     = bus.B_in;
                    state_d = S_MR;
                end
            end
            S_MR, S_MG: begin
                acc_y_d = acc_nxt_y;
                acc_u_d = acc_nxt_u;
                acc_v_d = acc_nxt_v;
                state_d = (state_q == S_MR) ? S_MG : S_MB;
            end
            S_MB: begin
                acc_y_d     = acc_nxt_y;
                acc_u_d     = acc_nxt_u;
                acc_v_d     = acc_nxt_v;
                y_out_d     = y_clip;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
`ifdef CHROMA_422_EN
                // Even pixel parks its chroma; odd pixel emits the rounded pair average
                if (!pair_q) begin
                    u_hold_d   = u_clip;
                    v_hold_d   = v_clip;
                    uv_valid_d = 1'b0;
                end else begin
                    u_out_d    = u_sum[8:1];
                    v_out_d    = v_sum[8:1];
                    uv_valid_d = 1'b1;
                end
`else
                u_out_d    = u_clip;
                v_out_d    = v_clip;
                uv_valid_d = 1'b1;
`endif
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
`ifdef CHROMA_422_EN
                    pair_d      = ~pair_q;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any pixel in flight
    always_ff @(posedge CLOCK_50_I) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            acc_y_q     <= '0;
            acc_u_q     <= '0;
            acc_v_q     <= '0;
            out_valid_q <= 1'b0;
            uv_valid_q  <= 1'b0;
            y_out_q     <= '0;
            u_out_q     <= '0;
            v_out_q     <= '0;
`ifdef CHROMA_422_EN
            pair_q      <= 1'b0;
            u_hold_q    <= '0;
            v_hold_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            acc_y_q     <= acc_y_d;
            acc_u_q     <= acc_u_d;
            acc_v_q     <= acc_v_d;
            out_valid_q <= out_valid_d;
            uv_valid_q  <= uv_valid_d;
            y_out_q     <= y_out_d;
            u_out_q     <= u_out_d;
            v_out_q     <= v_out_d;
`ifdef CHROMA_422_EN
            pair_q      <= pair_d;
            u_hold_q    <= u_hold_d;
            v_hold_q    <= v_hold_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.uv_valid  = uv_valid_q;
    assign bus.Y_out     = y_out_q;
    assign bus.U_out     = u_out_q;
    assign bus.V_out     = v_out_q;

endmodule

// File: tb/tb_rgb_to_yuv_converter.sv
// tb/tb_rgb_to_yuv_converter.sv - randomized self-checking bench for rgb_to_yuv_converter
module tb_rgb_to_yuv_converter;

    logic clk = 1'b0;
    logic resetn;

    always #10 clk = ~clk;

    rgb_to_yuv_converter_if bus ();

    rgb_to_yuv_converter #(.FRAC_BITS(16), .ACC_W(32)) dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int  exp_u_last = 0;
    int  exp_v_last = 0;
    int  hold_u     = 0;
    int  hold_v     = 0;
    bit  pair       = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clip8(input int x);
        if (x < 0)   return 0;
        if (x > 255) return 255;
        return x;
    endfunction

    function automatic void model(input int r, input int g, input int b,
                                  output int y, output int u, output int v);
        y = clip8(((r * 16843 + g * 33030 + b * 6423 + 32768) >>> 16) + 16);
        u = clip8(((r * -9699 + g * -19071 + b * 28770 + 32768) >>> 16) + 128);
        v = clip8(((r * 28770 + g * -24117 + b * -4653 + 32768) >>> 16) + 128);
    endfunction

    task automatic run_pixel(input int r, input int g, input int b, input int stall);
        int ey, eu, ev, euv, lat, n, pk;
        model(r, g, b, ey, eu, ev);
`ifdef CHROMA_422_EN
        if (!pair) begin
            hold_u = eu;
            hold_v = ev;
            eu     = exp_u_last;
            ev     = exp_v_last;
            euv    = 0;
        end else begin
            eu         = (hold_u + eu + 1) >> 1;
            ev         = (hold_v + ev + 1) >> 1;
            euv        = 1;
            exp_u_last = eu;
            exp_v_last = ev;
        end
        pair = ~pair;
`else
        euv        = 1;
        exp_u_last = eu;
        exp_v_last = ev;
`endif
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.R_in     = 8'(r);
        bus.G_in     = 8'(g);
        bus.B_in     = 8'(b);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", int'(bus.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 4);
        chk("y_out", int'(bus.Y_out), ey);
        chk("u_out", int'(bus.U_out), eu);
        chk("v_out", int'(bus.V_out), ev);
        chk("uv_valid", int'(bus.uv_valid), euv);
        pk = (1 << 26) | (ey << 17) | (eu << 9) | (ev << 1) | euv;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_hold", int'({bus.out_valid, bus.in_ready, bus.Y_out,
                                    bus.U_out, bus.V_out, bus.uv_valid}), pk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_hs_in_ready", int'(bus.in_ready), 1);
        chk("post_hs_out_valid", int'(bus.out_valid), 0);
    endtask

    task automatic reset_mid_conversion();
        bit seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.R_in     = 8'd200;
        bus.G_in     = 8'd40;
        bus.B_in     = 8'd90;
        chk("rst_in_ready_idle", int'(bus.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_y_out", int'(bus.Y_out), 0);
        chk("rst_u_out", int'(bus.U_out), 0);
        chk("rst_uv_valid", int'(bus.uv_valid), 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        chk("dropped_pixel", int'(seen), 0);
        pair       = 1'b0;
        exp_u_last = 0;
        exp_v_last = 0;
        hold_u     = 0;
        hold_v     = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.R_in      = '0;
        bus.G_in      = '0;
        bus.B_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_in_ready", int'(bus.in_ready), 1);
        chk("reset_uv_valid", int'(bus.uv_valid), 0);
        chk("reset_yuv", int'({bus.Y_out, bus.U_out, bus.V_out}), 0);

        run_pixel(255, 0, 0, 0);
        run_pixel(0, 0, 0, 10);
        run_pixel(255, 255, 255, 2);
        reset_mid_conversion();
        run_pixel(0, 0, 255, 0);
        run_pixel(255, 255, 0, 1);
        for (int k = 0; k < 24; k++) begin
            run_pixel(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
